ddr_app_responder: RTL and testbench



---
 rtl/ddr_app_pkg.sv | 27 ++
 rtl/app_sync_fifo.sv | 55 +++++
 rtl/ddr_app_responder.sv | 135 +++++++++++++
 tb/tb_ddr_app_responder.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_app_pkg.sv
// Shared definitions for the MIG 7-series app-interface responder and the
// benches that drive ddr_controller against it.
package ddr_app_pkg;

  localparam int APP_DATA_W = 128;
  localparam int APP_MASK_W = APP_DATA_W / 8;
  localparam int APP_ADDR_W = 28;
  localparam int APP_WORD_W = APP_ADDR_W - 3;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef struct packed {
    logic [2:0]            cmd;
    logic [APP_WORD_W-1:0] word;
  } cmd_entry_t;

  typedef struct packed {
    logic [APP_DATA_W-1:0] data;
    logic [APP_MASK_W-1:0] mask;
  } wdata_entry_t;

  function automatic logic cmd_is_legal(input logic [2:0] cmd);
    return (cmd == CMD_WRITE) || (cmd == CMD_READ);
  endfunction

endpackage

// File: rtl/app_sync_fifo.sv
// Single-clock show-ahead FIFO with registered full/empty flags; the head
// entry is visible on data_o whenever empty_o is low.
module app_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, rd_q, wr_d, rd_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;
  assign wr_d    = wr_q + (AW+1)'(do_push);
  assign rd_d    = rd_q + (AW+1)'(do_pop);

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      full_q  <= (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
      empty_q <= (wr_d == rd_d);
    end
  end

  // NOTE: storage arrays are deliberately not reset; the pointers alone
  // define which entries are meaningful, and a reset would block RAM mapping.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q[AW-1:0]] <= data_i;
  end

  assign data_o  = mem[rd_q[AW-1:0]];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/ddr_app_responder.sv
// Drop-in stand-in for mig_7series_0: queues app commands and write data,
// stores words in block RAM and returns reads after RD_LATENCY cycles.
module ddr_app_responder
  import ddr_app_pkg::*;
#(
  parameter int DDR_DATA_WIDTH = 128,
  parameter int DDR_ADDR_WIDTH = 28,
  parameter int MEM_AW         = 10,
  parameter int RD_LATENCY     = 4,
  parameter int INIT_CYCLES    = 64,
  parameter int REF_PERIOD     = 512,
  parameter int REF_CYCLES     = 8,
  parameter int QDEPTH         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        app_en,
  input  logic [2:0]                  app_cmd,
  input  logic [DDR_ADDR_WIDTH-1:0]   app_addr,
  output logic                        app_rdy,
  input  logic                        app_wdf_wren,
  input  logic                        app_wdf_end,
  input  logic [DDR_DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DDR_DATA_WIDTH/8-1:0] app_wdf_mask,
  output logic                        app_wdf_rdy,
  output logic [DDR_DATA_WIDTH-1:0]   app_rd_data,
  output logic                        app_rd_data_valid,
  output logic                        app_rd_data_end,
  output logic                        init_calib_complete,
  output logic                        err_flag
);

  localparam int CCW = $clog2(INIT_CYCLES + 1);
  localparam int RCW = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  logic [CCW-1:0] calib_cnt_q;
  logic           calib_done_q;
  logic [RCW-1:0] ref_cnt_q;
  logic           ref_win;
  logic           err_q;

  cmd_entry_t   cmd_in, cmd_head;
  wdata_entry_t wd_in, wd_head;
  logic cmd_full, cmd_empty, wd_full, wd_empty;
  logic cmd_acc, cmd_push, wd_push, exec_wr, exec_rd;

  logic [DDR_DATA_WIDTH-1:0] ram [2**MEM_AW];
  logic [DDR_DATA_WIDTH-1:0] dq_q [RD_LATENCY];
  logic [RD_LATENCY-1:0]     vld_q;
  logic [MEM_AW-1:0]         head_idx;

  // Refresh windows are phased from the first calibrated cycle, so the
  // k=0 window directly follows calibration.
  always_ff @(posedge clk) begin
    if (rst) begin
      calib_cnt_q  <= '0;
      calib_done_q <= 1'b0;
      ref_cnt_q    <= '0;
    end else begin
      if (!calib_done_q) begin
        calib_cnt_q <= calib_cnt_q + 1'b1;
        if (int'(calib_cnt_q) == INIT_CYCLES - 1) calib_done_q <= 1'b1;
      end else if (REF_PERIOD > 0) begin
        if (int'(ref_cnt_q) == REF_PERIOD - 1) ref_cnt_q <= '0;
        else                                   ref_cnt_q <= ref_cnt_q + 1'b1;
      end
    end
  end

  assign ref_win     = (REF_PERIOD > 0) && calib_done_q && (int'(ref_cnt_q) < REF_CYCLES);
  assign app_rdy     = calib_done_q && !cmd_full && !ref_win;
  assign app_wdf_rdy = calib_done_q && !wd_full;

  assign cmd_acc  = app_en && app_rdy;
  assign cmd_push = cmd_acc && cmd_is_legal(app_cmd);
  assign wd_push  = app_wdf_wren && app_wdf_rdy;
  assign cmd_in   = '{cmd: app_cmd, word: app_addr[DDR_ADDR_WIDTH-1:3]};
  assign wd_in    = '{data: app_wdf_data, mask: app_wdf_mask};

  app_sync_fifo #(.WIDTH($bits(cmd_entry_t)), .DEPTH(QDEPTH)) u_cmd_fifo (
    .clk(clk), .rst(rst), .push_i(cmd_push), .data_i(cmd_in),
    .pop_i(exec_wr || exec_rd), .data_o(cmd_head), .full_o(cmd_full), .empty_o(cmd_empty)
  );

  app_sync_fifo #(.WIDTH($bits(wdata_entry_t)), .DEPTH(QDEPTH)) u_wd_fifo (
    .clk(clk), .rst(rst), .push_i(wd_push), .data_i(wd_in),
    .pop_i(exec_wr), .data_o(wd_head), .full_o(wd_full), .empty_o(wd_empty)
  );

  // A write head without its data blocks the whole queue to keep ordering.
  assign exec_wr  = !rst && !cmd_empty && (cmd_head.cmd == CMD_WRITE) && !wd_empty;
  assign exec_rd  = !rst && !cmd_empty && (cmd_head.cmd == CMD_READ);
  assign head_idx = cmd_head.word[MEM_AW-1:0];

  always_ff @(posedge clk) begin
    if (exec_wr) begin
      for (int b = 0; b < DDR_DATA_WIDTH/8; b++) begin
        if (!wd_head.mask[b]) ram[head_idx][8*b +: 8] <= wd_head.data[8*b +: 8];
      end
    end
  end

  // Data stages advance only with their valid bit, so the output holds
  // the last returned word between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < RD_LATENCY; i++) dq_q[i] <= '0;
    end else begin
      vld_q[0] <= exec_rd;
      if (exec_rd) dq_q[0] <= ram[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dq_q[i] <= dq_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else if ((cmd_acc && !cmd_is_legal(app_cmd)) || (app_wdf_wren && !app_wdf_end) ||
             (app_wdf_wren && !app_wdf_rdy))
      err_q <= 1'b1;
  end

  assign app_rd_data         = dq_q[RD_LATENCY-1];
  assign app_rd_data_valid   = vld_q[RD_LATENCY-1];
  assign app_rd_data_end     = vld_q[RD_LATENCY-1];
  assign init_calib_complete = calib_done_q;
  assign err_flag            = err_q;

  logic unused_ok;
  assign unused_ok = ^{app_addr[2:0], cmd_head.word[APP_WORD_W-1:MEM_AW]};

endmodule

// File: tb/tb_ddr_app_responder.sv
// Directed bench for ddr_app_responder: table of write/read vectors plus
// hand-written sequences for stalls, queue full, refresh, illegal and reset.
module tb_ddr_app_responder;
  import ddr_app_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         app_en;
  logic [2:0]   app_cmd;
  logic [27:0]  app_addr;
  logic         app_rdy;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         init_calib_complete;
  logic         err_flag;

  int cyc = 0;
  int vcount = 0;
  int checks = 0;
  int failures = 0;

  ddr_app_responder dut (
    .clk(clk), .rst(rst),
    .app_en(app_en), .app_cmd(app_cmd), .app_addr(app_addr), .app_rdy(app_rdy),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .init_calib_complete(init_calib_complete),
    .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Cycle index since reset release: cycle k is the one after the k-th edge.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (app_rd_data_valid) vcount <= vcount + 1;
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Starts and ends just after a negedge; n = cycle in which it was accepted.
  task automatic issue(input logic [2:0] c, input logic [27:0] a, input logic with_data,
                       input logic [127:0] d, input logic [15:0] m, output int n);
    int t = 0;
    app_en = 1'b1; app_cmd = c; app_addr = a;
    while (!(app_rdy && (!with_data || app_wdf_rdy)) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) check("issue_timeout", 1'b1, 1'b0);
    app_wdf_wren = with_data; app_wdf_end = with_data;
    app_wdf_data = d; app_wdf_mask = m;
    n = cyc;
    @(negedge clk);
    app_en = 1'b0; app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
  endtask

  task automatic wait_valid(input int exp_cyc, input logic [127:0] exp, input string name);
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!app_rd_data_valid && t < 100);
    check({name, "_valid"}, app_rd_data_valid, 1'b1);
    check({name, "_data"}, app_rd_data, exp);
    check({name, "_cycle"}, cyc, exp_cyc);
    check({name, "_end"}, app_rd_data_end, 1'b1);
  endtask

  typedef struct {
    logic         wr;
    logic [27:0]  addr;
    logic [127:0] data;   // write data, or expected read data
    logic [15:0]  mask;
    string        name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n, n1, n2, acc, t, first_hi, base;
    logic early;
    logic rdy_seen[6];
    logic [127:0] a5, ones, mixed;
    a5    = {16{8'hA5}};
    ones  = {16{8'hFF}};
    mixed = 128'h0123456789ABCDEF_FEDCBA9876543210;

    vecs[0]  = '{1'b1, 28'h0000008, a5,         16'h0000, "w08"};
    vecs[1]  = '{1'b0, 28'h0000008, a5,         16'h0000, "rd_a5"};
    vecs[2]  = '{1'b1, 28'h0000010, ones,       16'h0000, "w10_ff"};
    vecs[3]  = '{1'b1, 28'h0000010, '0,         16'hFFFE, "w10_mask"};
    vecs[4]  = '{1'b0, 28'h0000010, {{15{8'hFF}}, 8'h00}, 16'h0000, "rd_mask"};
    vecs[5]  = '{1'b1, 28'h000001F, mixed,      16'h0000, "w1f"};
    vecs[6]  = '{1'b0, 28'h0000018, mixed,      16'h0000, "rd_lowbits_ignored"};
    vecs[7]  = '{1'b1, 28'h0000018, {16{8'h11}}, 16'h00FF, "w18_upper"};
    vecs[8]  = '{1'b0, 28'h0000018, 128'h1111111111111111_FEDCBA9876543210, 16'h0000, "rd_upper_merge"};
    vecs[9]  = '{1'b1, 28'h0001FF8, {4{32'hDEADBEEF}}, 16'h0000, "w_top"};
    vecs[10] = '{1'b0, 28'h0001FF8, {4{32'hDEADBEEF}}, 16'h0000, "rd_top"};
    vecs[11] = '{1'b0, 28'h0002008, a5,         16'h0000, "rd_alias"};

    rst = 1'b1; app_en = 1'b0; app_cmd = '0; app_addr = '0;
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0; app_wdf_data = '0; app_wdf_mask = '0;
    repeat (3) @(negedge clk);
    check("rst_rdy", app_rdy, 1'b0);
    check("rst_wdf_rdy", app_wdf_rdy, 1'b0);
    check("rst_calib", init_calib_complete, 1'b0);
    check("rst_valid", app_rd_data_valid, 1'b0);
    check("rst_rd_data", app_rd_data, '0);
    check("rst_err", err_flag, 1'b0);
    rst = 1'b0;

    // Calibration: first high cycle must be 64, no ready before it.
    first_hi = -1; early = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!init_calib_complete && (app_rdy || app_wdf_rdy)) early = 1'b1;
      if (init_calib_complete) begin
        first_hi = cyc;
        break;
      end
    end
    check("calib_cycle", first_hi, 64);
    check("ready_before_calib", early, 1'b0);
    check("no_valid_during_calib", vcount, 0);
    check("wdf_rdy_at_calib", app_wdf_rdy, 1'b1);
    check("rdy_ref0_start", app_rdy, 1'b0);
    t = 0;
    while (cyc < 71 && t < 100) begin @(negedge clk); t++; end
    check("rdy_ref0_last", app_rdy, 1'b0);
    @(negedge clk);
    check("rdy_after_ref0", app_rdy, 1'b1);

    for (int i = 0; i < 12; i++) begin
      if (vecs[i].wr) issue(CMD_WRITE, vecs[i].addr, 1'b1, vecs[i].data, vecs[i].mask, n);
      else begin
        issue(CMD_READ, vecs[i].addr, 1'b0, '0, '0, n);
        wait_valid(n + 5, vecs[i].data, vecs[i].name);
      end
    end

    // Back-to-back reads return back-to-back in order.
    issue(CMD_READ, 28'h08, 1'b0, '0, '0, n1);
    issue(CMD_READ, 28'h10, 1'b0, '0, '0, n2);
    wait_valid(n1 + 5, a5, "b2b_first");
    wait_valid(n1 + 6, {{15{8'hFF}}, 8'h00}, "b2b_second");

    // Write command at N, read at N+1, write data at N+3.
    issue(CMD_WRITE, 28'h40, 1'b0, '0, '0, n);
    issue(CMD_READ, 28'h40, 1'b0, '0, '0, n1);
    @(negedge clk);
    app_wdf_wren = 1'b1; app_wdf_end = 1'b1; app_wdf_data = {4{32'hCAFEF00D}}; app_wdf_mask = '0;
    @(negedge clk);
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    wait_valid(n + 9, {4{32'hCAFEF00D}}, "stall_rd");

    // Six write commands with the head stalled: only four fit.
    acc = 0;
    app_en = 1'b1; app_cmd = CMD_WRITE;
    for (int k = 0; k < 6; k++) begin
      app_addr = 28'h100 + 28'(8 * k);
      rdy_seen[k] = app_rdy;
      if (app_rdy) acc++;
      @(negedge clk);
    end
    app_en = 1'b0;
    check("full_accepted", acc, 4);
    check("full_rdy5", rdy_seen[4], 1'b0);
    check("full_rdy6", rdy_seen[5], 1'b0);
    for (int k = 0; k < 4; k++) begin
      app_wdf_wren = 1'b1; app_wdf_end = 1'b1;
      app_wdf_data = {4{32'h1000_0000 + 32'(k)}}; app_wdf_mask = '0;
      @(negedge clk);
    end
    app_wdf_wren = 1'b0; app_wdf_end = 1'b0;
    repeat (3) @(negedge clk);
    check("rdy_after_drain", app_rdy, 1'b1);
    issue(CMD_READ, 28'h100, 1'b0, '0, '0, n);
    wait_valid(n + 5, {4{32'h1000_0000}}, "drain_rd0");
    issue(CMD_READ, 28'h118, 1'b0, '0, '0, n);
    wait_valid(n + 5, {4{32'h1000_0003}}, "drain_rd3");

    // Refresh window at 512 after calib = cycles 576..583; queue drains inside it.
    t = 0;
    while (cyc < 575 && t < 1000) begin @(negedge clk); t++; end
    check("ref_pre_rdy", app_rdy, 1'b1);
    issue(CMD_READ, 28'h08, 1'b0, '0, '0, n);
    check("ref_start_rdy", app_rdy, 1'b0);
    wait_valid(n + 5, a5, "ref_drain_rd");
    t = 0;
    while (cyc < 583 && t < 100) begin @(negedge clk); t++; end
    check("ref_last_rdy", app_rdy, 1'b0);
    @(negedge clk);
    check("ref_end_rdy", app_rdy, 1'b1);

    // Illegal command: flags error, leaves RAM untouched.
    check("err_before_illegal", err_flag, 1'b0);
    issue(3'b111, 28'h08, 1'b0, '0, '0, n);
    check("err_after_illegal", err_flag, 1'b1);
    issue(CMD_READ, 28'h08, 1'b0, '0, '0, n);
    wait_valid(n + 5, a5, "rd_after_illegal");

    // Reset with two reads in flight.
    issue(CMD_READ, 28'h10, 1'b0, '0, '0, n);
    issue(CMD_READ, 28'h08, 1'b0, '0, '0, n);
    base = vcount;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_err", err_flag, 1'b0);
    check("midrst_calib", init_calib_complete, 1'b0);
    check("midrst_rdy", app_rdy, 1'b0);
    repeat (30) @(negedge clk);
    check("midrst_no_valid", vcount, base);
    issue(CMD_READ, 28'h08, 1'b0, '0, '0, n);
    check("post_rst_issue_cycle", n, 72);
    wait_valid(n + 5, a5, "post_rst_rd08");
    issue(CMD_READ, 28'h10, 1'b0, '0, '0, n);
    wait_valid(n + 5, {{15{8'hFF}}, 8'h00}, "post_rst_rd10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
